reduce_add_uint8: RTL and testbench

Streaming reduction stage directly downstream of the uint8 multiplier: consumes one 8-bit product per valid cycle and sums each consecutive group of N products into one 8-bit result. Completed sums are buffered in a small result FIFO and offered downstream on a valid/ready handshake. The multiplier pipeline cannot stall, so the input side has no ready. A result that arrives while the FIFO is full is dropped and flagged.

---
 rtl/aetherling_pkg.sv | 8 +
 rtl/reduce_result_fifo.sv | 69 ++++++
 rtl/reduce_add_uint8.sv | 102 ++++++++++
 tb/tb_reduce_add_uint8.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/aetherling_pkg.sv
// Shared types and constants for the aetherling uint8 streaming blocks.
package aetherling_pkg;

    typedef logic [7:0] uint8_t;

    localparam uint8_t UINT8_MAX = 8'd255;

endpackage

// File: rtl/reduce_result_fifo.sv
// Small result FIFO for reduce_add_uint8: power-of-two depth, 8-bit entries.
// The parent only asserts push when the write is accepted and only asserts
// pop when the FIFO is non-empty. Storage is reset so head data is never X.
module reduce_result_fifo
    import aetherling_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  uint8_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output uint8_t head
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    uint8_t             mem_q [FIFO_DEPTH];
    uint8_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/reduce_add_uint8.sv
// Streaming reduction: sums each group of N uint8 products into one uint8
// result and buffers results in a small FIFO with a valid/ready output.
// Define SATURATE_EN to make the add saturate at 255 instead of wrapping.
// Input side cannot stall: a result arriving while the FIFO is full (and not
// popping) is dropped and the sticky overflow flag is set.
module reduce_add_uint8
    import aetherling_pkg::*;
#(
    parameter int N          = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  uint8_t I,
    input  logic   valid_in,
    output uint8_t O,
    output logic   valid_out,
    input  logic   ready_out,
    output logic   overflow
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Group adder: wraps mod 256, or clamps to 255 when saturation is built in.
    function automatic uint8_t add_op(input uint8_t a, input uint8_t b);
`ifdef SATURATE_EN
        logic [8:0] sum;
        sum    = {1'b0, a} + {1'b0, b};
        add_op = (sum > {1'b0, UINT8_MAX}) ? UINT8_MAX : sum[7:0];
`else
        add_op = a + b;
`endif
    endfunction

    uint8_t           acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overflow_q, overflow_d;

    uint8_t group_sum;
    logic   group_done;
    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_full;
    logic   fifo_empty;
    uint8_t fifo_head;

    // Accumulate, decide push vs drop, and update the sticky overflow flag.
    always_comb begin
        group_sum  = add_op(acc_q, I);
        group_done = valid_in && (cnt_q == CNT_W'(N - 1));
        fifo_pop   = !fifo_empty && ready_out;
        // A full FIFO still accepts the write when its head leaves on this edge.
        fifo_push  = group_done && (!fifo_full || fifo_pop);
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        if (valid_in) begin
            if (group_done) begin
                // Restart even on a drop so later groups stay aligned.
                acc_d = '0;
                cnt_d = '0;
                if (!fifo_push) begin
                    overflow_d = 1'b1;
                end
            end else begin
                acc_d = group_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Accumulator, group counter and overflow flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    reduce_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (group_sum),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign O         = fifo_head;
    assign valid_out = !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_reduce_add_uint8.sv
// Testbench for reduce_add_uint8: an N=4 instance and an N=1 instance, each
// with an expected-result queue filled by stimulus and drained by a monitor.
module tb_reduce_add_uint8;

    logic       clk;
    logic       rst_n;

    logic [7:0] i4, o4;
    logic       v4, vo4, r4, ov4;
    logic [7:0] i1, o1;
    logic       v1, vo1, r1, ov1;

    int total;
    int bad;

    logic [7:0] q4[$];
    logic [7:0] q1[$];

    reduce_add_uint8 #(.N(4), .FIFO_DEPTH(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .I(i4), .valid_in(v4),
        .O(o4), .valid_out(vo4), .ready_out(r4), .overflow(ov4)
    );

    reduce_add_uint8 #(.N(1), .FIFO_DEPTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .I(i1), .valid_in(v1),
        .O(o1), .valid_out(vo1), .ready_out(r1), .overflow(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitors: a transfer happens on the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (rst_n && vo4 && r4) begin
            total++;
            if (q4.size() == 0) begin
                bad++;
                $display("FAIL n4_unexpected: got %0d expected none", o4);
            end else begin
                logic [7:0] e;
                e = q4.pop_front();
                if (o4 !== e) begin
                    bad++;
                    $display("FAIL n4_result: got %0d expected %0d", o4, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && vo1 && r1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL n1_unexpected: got %0d expected none", o1);
            end else begin
                logic [7:0] e;
                e = q1.pop_front();
                if (o1 !== e) begin
                    bad++;
                    $display("FAIL n1_result: got %0d expected %0d", o1, e);
                end
            end
        end
    end

    task automatic step4(input logic v, input logic [7:0] d);
        v4 = v;
        i4 = d;
        @(posedge clk);
        #1;
        v4 = 1'b0;
    endtask

    task automatic step1(input logic v, input logic [7:0] d);
        v1 = v;
        i1 = d;
        @(posedge clk);
        #1;
        v1 = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (q4.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, q4.size() + q1.size());
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_o4", o4, 8'd0);
        chk("rst_vo4", {7'd0, vo4}, 8'd0);
        chk("rst_ov4", {7'd0, ov4}, 8'd0);
        chk("rst_o1", o1, 8'd0);
        chk("rst_vo1", {7'd0, vo1}, 8'd0);
        chk("rst_ov1", {7'd0, ov1}, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        i4 = '0; v4 = 1'b0; r4 = 1'b1;
        i1 = '0; v1 = 1'b0; r1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("init_o4", o4, 8'd0);
        chk("init_vo4", {7'd0, vo4}, 8'd0);
        chk("init_ov4", {7'd0, ov4}, 8'd0);
        chk("init_vo1", {7'd0, vo1}, 8'd0);
        rst_n = 1'b1;

        // Basic group 1,2,3,4 -> 10, visible right after the 4th edge, for one cycle.
        step4(1'b1, 8'd1);
        step4(1'b1, 8'd2);
        step4(1'b1, 8'd3);
        chk("basic_not_early", {7'd0, vo4}, 8'd0);
        q4.push_back(8'd10);
        step4(1'b1, 8'd4);
        chk("basic_latency_v", {7'd0, vo4}, 8'd1);
        chk("basic_latency_o", o4, 8'd10);
        step4(1'b0, 8'd0);
        chk("basic_one_cycle", {7'd0, vo4}, 8'd0);

        // Gapped group 5,-,6,-,-,7,8 -> 26.
        step4(1'b1, 8'd5);
        step4(1'b0, 8'd0);
        step4(1'b1, 8'd6);
        step4(1'b0, 8'd0);
        step4(1'b0, 8'd0);
        step4(1'b1, 8'd7);
        chk("gap_not_early", {7'd0, vo4}, 8'd0);
        q4.push_back(8'd26);
        step4(1'b1, 8'd8);
        drain("gap");

        // 100 x 4: wraps to 144, or clamps to 255 when saturating.
`ifdef SATURATE_EN
        q4.push_back(8'd255);
`else
        q4.push_back(8'd144);
`endif
        for (int k = 0; k < 4; k++) step4(1'b1, 8'd100);
        drain("ovf_arith");

        // Reset mid-group: partial 9+9 discarded, then 1,1,1,1 -> 4.
        step4(1'b1, 8'd9);
        step4(1'b1, 8'd9);
        pulse_reset();
        step4(1'b1, 8'd1);
        step4(1'b1, 8'd1);
        step4(1'b1, 8'd1);
        chk("rst_grp_not_early", {7'd0, vo4}, 8'd0);
        q4.push_back(8'd4);
        step4(1'b1, 8'd1);
        chk("rst_grp_o", o4, 8'd4);
        drain("rst_grp");

        // N=1 throughput: one result per cycle with ready held high.
        r1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            q1.push_back(8'(k));
            step1(1'b1, 8'(k));
        end
        chk("n1_tput_o", o1, 8'd5);
        chk("n1_tput_v", {7'd0, vo1}, 8'd1);
        drain("n1_tput");

        // Backpressure: 10,20 buffered, 30 dropped, overflow sticks.
        r1 = 1'b0;
        q1.push_back(8'd10);
        q1.push_back(8'd20);
        step1(1'b1, 8'd10);
        step1(1'b1, 8'd20);
        chk("bp_no_ovf_yet", {7'd0, ov1}, 8'd0);
        step1(1'b1, 8'd30);
        chk("bp_ovf_set", {7'd0, ov1}, 8'd1);
        chk("bp_head", o1, 8'd10);
        chk("bp_valid", {7'd0, vo1}, 8'd1);
        step1(1'b0, 8'd0);
        chk("bp_head_stable", o1, 8'd10);
        r1 = 1'b1;
        drain("bp");
        chk("bp_ovf_sticky", {7'd0, ov1}, 8'd1);
        chk("bp_empty", {7'd0, vo1}, 8'd0);

        pulse_reset();
        chk("ovf_cleared", {7'd0, ov1}, 8'd0);

        // Full FIFO with push and pop on the same edge: nothing dropped.
        r1 = 1'b0;
        q1.push_back(8'd10);
        q1.push_back(8'd20);
        step1(1'b1, 8'd10);
        step1(1'b1, 8'd20);
        r1 = 1'b1;
        q1.push_back(8'd30);
        step1(1'b1, 8'd30);
        chk("pp_no_ovf", {7'd0, ov1}, 8'd0);
        chk("pp_head", o1, 8'd20);
        drain("pp");
        chk("pp_no_ovf_end", {7'd0, ov1}, 8'd0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
